novacore_cfg_loader: RTL and testbench
======================================

# novacore_cfg_loader

Byte-stream configuration loader that sits directly upstream of the NovaCORE fabric and drives its configuration port (`mode`, `c_bus`, `c_uid`, `c_clk`). It accepts a framed byte stream over a valid/ready handshake, assembles 24-bit configuration words and presents each one to the fabric with a generated `c_clk` strobe that has defined setup, high and hold phases. When the stream is complete it releases the fabric into run mode.

## Interface
Parameters:
- `BUS_W`, 18: width of `c_bus`; `UID_W + BUS_W` must be at most 22.
- `UID_W`, 4: width of `c_uid`.
- `PH_CYC`, 2: `clk` cycles per `c_clk` phase (setup, high, hold); minimum 1.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mode`  out  1  1 = fabric in configuration mode, 0 = run.
- `c_bus`  out  `BUS_W`  configuration data.
- `c_uid`  out  `UID_W`  target unit id.
- `c_clk`  out  1  configuration strobe.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; level output.
- `error`  out  1  the last load aborted; level output.

## Operation
- Stream format: 2-byte frame count N (big-endian), then N frames of 3 bytes (W = {b0,b1,b2}), then one checksum byte if `NOVACORE_CFG_CHECKSUM_EN` is defined.
- Frame word fields: `c_uid` = W[21:18], `c_bus` = W[17:0]. W[23:22] are reserved and must be 0.
- States: IDLE, HDR0, HDR1, FRAME, SETUP, STROBE, HOLD, CHECK (macro only), DONE, ERR.
- `start` moves the FSM to HDR0 and clears `done` and `error`.
- HDR0 and HDR1 each consume one byte. The FSM then goes to FRAME, or to CHECK/DONE if N = 0.
- FRAME consumes 3 bytes using a byte counter 0..2.
  - On the third byte, if W[23:22] is nonzero, go to ERR.
  - Otherwise register `c_uid` and `c_bus` and go to SETUP.
- SETUP → STROBE → HOLD, each lasting `PH_CYC` cycles.
  - `c_clk` is 1 only in STROBE.
  - `c_bus` and `c_uid` are stable from SETUP entry through HOLD exit.
- After HOLD, the 16-bit remaining-frame counter decrements. At 0 the FSM goes to CHECK/DONE, otherwise back to FRAME.
- DONE: `mode` = 0, `done` = 1.
- ERR: `mode` stays 1, `error` = 1, and `c_clk` is never pulsed again.
- `start` while `busy` is ignored.
- `in_ready` = 1 only in HDR0, HDR1, FRAME and CHECK. A byte transfers when `in_valid` and `in_ready` are both 1.
- `in_valid` low stalls the FSM indefinitely with no timeout. Outputs hold their values during a stall.

## Timing
- Reset values: `mode` = 1, `c_bus` = 0, `c_uid` = 0, `c_clk` = 0, `in_ready` = 0, `busy` = 0, `done` = 0, `error` = 0; FSM in IDLE.
- `rst` mid-load forces the reset values at the next edge. `c_clk` drops within one cycle and no partial strobe is extended.
- All outputs are registered.
- Third frame byte accepted at edge T:
  - `c_bus` and `c_uid` update at T+1.
  - `c_clk` rises at T+1+`PH_CYC` and falls at T+1+2·`PH_CYC`.
  - `in_ready` reasserts at T+1+3·`PH_CYC`.
- Per-frame minimum: 3 + 3·`PH_CYC` cycles.
- `busy` is 1 from the cycle after `start` until DONE or ERR is entered.
- `done` and `error` assert on the cycle of state entry and hold until `start` or `rst`.
- `start` coincident with `in_valid` in IDLE: the byte is not consumed, because `in_ready` is 0 in IDLE.

## Configuration
- `NOVACORE_CFG_CHECKSUM_EN` defined:
  - An 8-bit running XOR is kept over all header and frame bytes.
  - CHECK consumes one byte. If it equals the XOR, go to DONE; otherwise go to ERR.
  - Frames already strobed into the fabric are not undone.
- Macro undefined: the CHECK state, the XOR register and the trailing byte do not exist. The FSM goes directly to DONE.

## Structure
- Shared package `novacore_cfg_pkg` holds:
  - the FSM state enum;
  - `CFG_FRAME_BYTES` = 3;
  - `CFG_HDR_BYTES` = 2;
  - the reserved-field bit positions.
- One sub-module, `novacore_cfg_strobe`: the SETUP/STROBE/HOLD phase timer.
  - Parameter `PH_CYC`.
  - Inputs `go`; outputs `c_clk`, `fin`.
- Everything else stays in the top FSM.

## Test plan
- N = 1, frame 0x0C_0001, `PH_CYC` = 2, `in_valid` always 1:
  - `c_uid` = 3, `c_bus` = 0x00001;
  - exactly one `c_clk` pulse, 2 cycles wide, 2 cycles after `c_bus` settles;
  - `done` = 1, `mode` = 0.
- N = 0: no `c_clk` pulse, and `done` asserts after the header (after the checksum byte 0x00 when the macro is defined).
- N = 2 with `in_valid` gaps of 5 cycles between bytes: both frames strobe in order and the gaps stretch only the FRAME state.
- Frame byte0 = 0xC0: `error` = 1, `mode` = 1, no `c_clk` pulse.
- Macro defined, N = 1, wrong checksum: the frame is strobed, then `error` = 1 and `mode` stays 1. The correct checksum gives `done` = 1.
- `rst` asserted during STROBE: the next cycle shows `c_clk` = 0, `busy` = 0, `mode` = 1. A fresh `start` then loads correctly.

Source files
------------

// File: rtl/novacore_cfg_pkg.sv
// Shared types and constants for the NovaCORE configuration loader: FSM states,
// strobe-timer phases, stream framing sizes and reserved-field positions.
package novacore_cfg_pkg;

  localparam int CFG_FRAME_BYTES = 3;
  localparam int CFG_HDR_BYTES   = 2;
  localparam int CFG_WORD_W      = 8 * CFG_FRAME_BYTES;
  localparam int CFG_RSV_HI      = 23;
  localparam int CFG_RSV_LO      = 22;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_FRAME,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_SETUP,
    STB_HIGH,
    STB_HOLD
  } stb_phase_t;

endpackage

// File: rtl/novacore_cfg_strobe.sv
// c_clk phase timer: after a one-cycle go, runs SETUP/HIGH/HOLD of PH_CYC cycles each.
// Latency: c_clk rises PH_CYC cycles after go is taken; fin marks the last HOLD cycle.
module novacore_cfg_strobe
  import novacore_cfg_pkg::*;
#(
  parameter int PH_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic c_clk,
  output logic fin
);

  localparam int CW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PH_CYC - 1);

  stb_phase_t      phase;
  logic [CW-1:0]   cnt;

  assign fin = (phase == STB_HOLD) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= STB_IDLE;
      cnt   <= '0;
      c_clk <= 1'b0;
    end else if (go) begin
      phase <= STB_SETUP;
      cnt   <= '0;
      c_clk <= 1'b0;
    end else if (phase != STB_IDLE) begin
      if (cnt == LAST) begin
        cnt <= '0;
        case (phase)
          STB_SETUP: begin
            phase <= STB_HIGH;
            c_clk <= 1'b1;
          end
          STB_HIGH: begin
            phase <= STB_HOLD;
            c_clk <= 1'b0;
          end
          default: phase <= STB_IDLE;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/novacore_cfg_loader.sv
// Framed byte stream -> NovaCORE config port; 3+3*PH_CYC cycles/frame, stalls while in_valid low.
// in_ready only in header/frame/check states; NOVACORE_CFG_CHECKSUM_EN adds a trailing XOR byte.
module novacore_cfg_loader
  import novacore_cfg_pkg::*;
#(
  parameter int BUS_W  = 18,
  parameter int UID_W  = 4,
  parameter int PH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mode,
  output logic [BUS_W-1:0] c_bus,
  output logic [UID_W-1:0] c_uid,
  output logic             c_clk,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CNT_W = 8 * CFG_HDR_BYTES;

`ifdef NOVACORE_CFG_CHECKSUM_EN
  localparam cfg_state_t END_ST = ST_CHECK;
`else
  localparam cfg_state_t END_ST = ST_DONE;
`endif
  localparam logic END_CHK = (END_ST == ST_CHECK);

  cfg_state_t              state;
  logic [CNT_W-1:0]        frames_left;
  logic [1:0]              byte_cnt;
  logic [7:0]              b0, b1;
  logic [CFG_WORD_W-1:0]   word;
  logic                    xfer, can_start, last_byte, rsv_bad, go, fin;

  assign xfer      = in_valid & in_ready;
  assign can_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign word      = {b0, b1, in_data};
  assign last_byte = (state == ST_FRAME) && xfer && (byte_cnt == 2'(CFG_FRAME_BYTES - 1));
  assign rsv_bad   = |word[CFG_RSV_HI:CFG_RSV_LO];
  assign go        = last_byte && !rsv_bad;

`ifdef NOVACORE_CFG_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst || can_start) begin
      csum <= '0;
    end else if (xfer && state != ST_CHECK) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  novacore_cfg_strobe #(
    .PH_CYC (PH_CYC)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .c_clk (c_clk),
    .fin   (fin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      frames_left <= '0;
      byte_cnt    <= '0;
      b0          <= '0;
      b1          <= '0;
      c_bus       <= '0;
      c_uid       <= '0;
      mode        <= 1'b1;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (can_start) begin
            state    <= ST_HDR0;
            byte_cnt <= '0;
            mode     <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        ST_HDR0: begin
          if (xfer) begin
            frames_left[CNT_W-1:8] <= in_data;
            state                  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (xfer) begin
            frames_left[7:0] <= in_data;
            if ({frames_left[CNT_W-1:8], in_data} == '0) begin
              state    <= END_ST;
              in_ready <= END_CHK;
              busy     <= END_CHK;
              mode     <= END_CHK;
              done     <= !END_CHK;
            end else begin
              state <= ST_FRAME;
            end
          end
        end
        ST_FRAME: begin
          if (xfer) begin
            case (byte_cnt)
              2'd0:    b0 <= in_data;
              2'd1:    b1 <= in_data;
              default: ;
            endcase
            if (last_byte) begin
              byte_cnt <= '0;
              in_ready <= 1'b0;
              if (rsv_bad) begin
                state <= ST_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else begin
                state <= ST_SETUP;
                c_bus <= word[BUS_W-1:0];
                c_uid <= word[BUS_W +: UID_W];
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        // c_clk is registered in the timer, so these labels trail it by a cycle; fin decides the exit.
        ST_SETUP, ST_STROBE, ST_HOLD: begin
          if (fin) begin
            frames_left <= frames_left - 1'b1;
            if (frames_left == CNT_W'(1)) begin
              state    <= END_ST;
              in_ready <= END_CHK;
              busy     <= END_CHK;
              mode     <= END_CHK;
              done     <= !END_CHK;
            end else begin
              state    <= ST_FRAME;
              in_ready <= 1'b1;
            end
          end else if (state == ST_SETUP && c_clk) begin
            state <= ST_STROBE;
          end else if (state == ST_STROBE && !c_clk) begin
            state <= ST_HOLD;
          end
        end
`ifdef NOVACORE_CFG_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
              mode  <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Directed bench for novacore_cfg_loader: single-frame vector table plus
// hand-written multi-frame, empty-stream, checksum and mid-strobe reset sequences.
module tb_novacore_cfg_loader;

  localparam int PH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mode, c_clk, busy, done, error;
  logic [17:0] c_bus;
  logic [3:0]  c_uid;

  novacore_cfg_loader #(
    .BUS_W  (18),
    .UID_W  (4),
    .PH_CYC (PH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .c_bus    (c_bus),
    .c_uid    (c_uid),
    .c_clk    (c_clk),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Strobe monitor: logs each c_clk pulse (word, width, setup, hold) on negedges.
  logic [21:0] mon_word;
  assign mon_word = {c_uid, c_bus};

  int          cyc = 0, pulses = 0, rise_cyc = 0, fall_cyc = 0, chg_cyc = 0, viol = 0;
  logic        prev_clk = 1'b0, prev_rdy = 1'b0, fall_pend = 1'b0;
  logic [21:0] prev_word = '0;
  logic [21:0] word_log [64];
  int          width_log [64];
  int          setup_log [64];
  int          hold_log [64];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_clk  <= c_clk;
    prev_rdy  <= in_ready;
    prev_word <= mon_word;
    if (mon_word != prev_word) chg_cyc <= cyc;
    if (c_clk && !prev_clk) begin
      rise_cyc <= cyc;
      pulses   <= pulses + 1;
      if (pulses < 64) begin
        word_log[pulses]  <= mon_word;
        setup_log[pulses] <= (mon_word != prev_word) ? 0 : cyc - chg_cyc;
      end
    end
    if (!c_clk && prev_clk) begin
      fall_cyc  <= cyc;
      fall_pend <= 1'b1;
      if (pulses > 0 && pulses <= 64) width_log[pulses-1] <= cyc - rise_cyc;
    end
    if (in_ready && !prev_rdy && fall_pend) begin
      fall_pend <= 1'b0;
      if (pulses > 0 && pulses <= 64) hold_log[pulses-1] <= cyc - fall_cyc;
    end
    if (c_clk && mon_word != prev_word) viol <= viol + 1;
  end

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic        err;
    logic [3:0]  uid;
    logic [17:0] bus;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  stream [$];
  logic [3:0]  exp_uid = '0;
  logic [17:0] exp_bus = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'hA5;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input int gap, input int poke_at);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == poke_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      send_byte(stream[i]);
    end
  endtask

  task automatic do_start(input bit pre_valid);
    @(posedge clk); #1;
    if (pre_valid) begin
      in_valid = 1'b1;
      in_data  = stream[0];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_mode", mode, 1);
    check("start_ready", in_ready, 1);
  endtask

  task automatic wait_end();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done || error) seen = 1'b1;
    end
    if (!seen) check("end_timeout", 32'd0, 32'd1);
    repeat (3 * PH + 4) @(negedge clk);
  endtask

  task automatic load_vector(input vec_t v, input bit pre_valid, input int idx);
    int p;
    stream = '{8'h00, 8'h01, v.b0, v.b1, v.b2};
`ifdef NOVACORE_CFG_CHECKSUM_EN
    if (!v.err) stream.push_back(8'h01 ^ v.b0 ^ v.b1 ^ v.b2);
`endif
    p = pulses;
    do_start(pre_valid);
    send_stream(0, -1);
    wait_end();
    if (!v.err) begin
      exp_uid = v.uid;
      exp_bus = v.bus;
    end
    check($sformatf("v%0d_pulses", idx), pulses - p, v.err ? 0 : 1);
    check($sformatf("v%0d_uid", idx), c_uid, exp_uid);
    check($sformatf("v%0d_bus", idx), c_bus, exp_bus);
    check($sformatf("v%0d_done", idx), done, !v.err);
    check($sformatf("v%0d_error", idx), error, v.err);
    check($sformatf("v%0d_mode", idx), mode, v.err);
    check($sformatf("v%0d_busy", idx), busy, 0);
    if (!v.err) begin
      check($sformatf("v%0d_word", idx), word_log[p], {v.uid, v.bus});
      check($sformatf("v%0d_width", idx), width_log[p], PH);
      check($sformatf("v%0d_setup", idx), setup_log[p], PH);
    end
  endtask

  initial begin
    int p;
    bit hit;

    vecs[0] = '{8'h0C, 8'h00, 8'h01, 1'b0, 4'h3, 18'h00001};
    vecs[1] = '{8'h3F, 8'hFF, 8'hFF, 1'b0, 4'hF, 18'h3FFFF};
    vecs[2] = '{8'hC0, 8'h00, 8'h01, 1'b1, 4'h0, 18'h00000};
    vecs[3] = '{8'h02, 8'hAB, 8'hCD, 1'b0, 4'h0, 18'h2ABCD};
    vecs[4] = '{8'h40, 8'h12, 8'h34, 1'b1, 4'h0, 18'h00000};
    vecs[5] = '{8'h28, 8'h00, 8'h00, 1'b0, 4'hA, 18'h00000};
    vecs[6] = '{8'h80, 8'h00, 8'h00, 1'b1, 4'h0, 18'h00000};
    vecs[7] = '{8'h15, 8'h55, 8'h55, 1'b0, 4'h5, 18'h15555};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mode", mode, 1);
    check("rst_bus", c_bus, 0);
    check("rst_uid", c_uid, 0);
    check("rst_cclk", c_clk, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);

    for (int i = 0; i < 8; i++) load_vector(vecs[i], i == 0, i);

    // Empty stream: header only.
    stream = '{8'h00, 8'h00};
`ifdef NOVACORE_CFG_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    p = pulses;
    do_start(1'b0);
    send_stream(0, -1);
    wait_end();
    check("n0_pulses", pulses - p, 0);
    check("n0_done", done, 1);
    check("n0_error", error, 0);
    check("n0_mode", mode, 0);

    // Two frames with 5-cycle gaps and a start pulse mid-frame that must be ignored.
    stream = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h07, 8'h08, 8'h00, 8'h09};
`ifdef NOVACORE_CFG_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    p = pulses;
    do_start(1'b0);
    send_stream(5, 4);
    wait_end();
    check("n2_pulses", pulses - p, 2);
    check("n2_word0", word_log[p], 22'h040007);
    check("n2_word1", word_log[p+1], 22'h080009);
    check("n2_width0", width_log[p], PH);
    check("n2_width1", width_log[p+1], PH);
    check("n2_setup1", setup_log[p+1], PH);
    check("n2_hold0", hold_log[p], PH);
    check("n2_done", done, 1);
    check("n2_mode", mode, 0);

`ifdef NOVACORE_CFG_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h0C, 8'h00, 8'h01, 8'h5A};
    p = pulses;
    do_start(1'b0);
    send_stream(0, -1);
    wait_end();
    check("bad_csum_pulses", pulses - p, 1);
    check("bad_csum_error", error, 1);
    check("bad_csum_done", done, 0);
    check("bad_csum_mode", mode, 1);
`endif

    // Reset while c_clk is high.
    stream = '{8'h00, 8'h01, 8'h10, 8'h00, 8'h02};
    p = pulses;
    do_start(1'b0);
    send_stream(0, -1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (c_clk) hit = 1'b1;
    end
    check("rst_strobe_seen", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cclk", c_clk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mode", mode, 1);
    check("midrst_bus", c_bus, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    exp_uid = '0;
    exp_bus = '0;
    repeat (3) @(negedge clk);
    check("midrst_width", width_log[p], 1);
    load_vector(vecs[0], 1'b0, 8);

    check("bus_stable_during_strobe", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
